// File: rtl/aes256_inv_key_sched.sv
// AES-256 key schedule that delivers round keys in reverse order (14 down to 0),
// as a decryption datapath consumes them. Each cycle in EXPAND produces the
// next eight schedule words, and the round keys are stored in a small array.
// SERVE then hands the keys out over a valid/ready handshake.
module aes256_inv_key_sched (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [255:0] key_in,
  input  logic         key_valid,
  output logic         key_ready,
  output logic [127:0] rk_out,
  output logic [3:0]   rk_idx,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, EXPAND, SERVE} state_t;

  // Forward AES S-box. Entry 0 is in the top byte, so index with {~b, 3'b000}.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TABLE[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] x);
    return {x[23:0], x[31:24]};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  state_t         state_reg, state_next;
  logic [255:0]   w_reg;
  logic [7:0]     rc_reg;
  logic [2:0]     iter_reg;
  logic [3:0]     idx_reg;
  logic [127:0]   rk_mem [16];

  logic           load_en;
  logic           step_en;
  logic [31:0]    w_cur [8];
  logic [31:0]    w_nxt [8];
  logic [255:0]   w_step;
  logic [3:0]     rk_addr_even;

  // Split the packed word register into w0..w7 and repack the step result.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_words
      assign w_cur[gi] = w_reg[255 - 32*gi -: 32];
      assign w_step[255 - 32*gi -: 32] = w_nxt[gi];
    end
  endgenerate

  // One AES-256 schedule step: eight new words from the previous eight.
  always_comb begin
    w_nxt[0] = w_cur[0] ^ sub_word(rot_word(w_cur[7])) ^ {rc_reg, 24'h0};
    w_nxt[1] = w_cur[1] ^ w_nxt[0];
    w_nxt[2] = w_cur[2] ^ w_nxt[1];
    w_nxt[3] = w_cur[3] ^ w_nxt[2];
    w_nxt[4] = w_cur[4] ^ sub_word(w_nxt[3]);
    w_nxt[5] = w_cur[5] ^ w_nxt[4];
    w_nxt[6] = w_cur[6] ^ w_nxt[5];
    w_nxt[7] = w_cur[7] ^ w_nxt[6];
  end

  assign rk_addr_even = {iter_reg, 1'b0} + 4'd2;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    state_next = state_reg;
    key_ready  = 1'b0;
    busy       = 1'b0;
    rk_valid   = 1'b0;
    load_en    = 1'b0;
    step_en    = 1'b0;
    case (state_reg)
      IDLE: begin
        key_ready = 1'b1;
        if (key_valid) begin
          load_en    = 1'b1;
          state_next = EXPAND;
        end
      end
      EXPAND: begin
        busy    = 1'b1;
        step_en = 1'b1;
        if (iter_reg == 3'd6) state_next = SERVE;
      end
      SERVE: begin
        busy     = 1'b1;
        rk_valid = 1'b1;
        if (rk_ready && idx_reg == 4'd0) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Schedule words, round constant, step counter and serve index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_reg    <= '0;
      rc_reg   <= 8'h01;
      iter_reg <= 3'd0;
      idx_reg  <= 4'd0;
    end else if (load_en) begin
      w_reg    <= key_in;
      rc_reg   <= 8'h01;
      iter_reg <= 3'd0;
    end else if (step_en) begin
      w_reg    <= w_step;
      rc_reg   <= xtime(rc_reg);
      iter_reg <= iter_reg + 3'd1;
      if (iter_reg == 3'd6) idx_reg <= 4'd14;
    end else if (rk_valid && rk_ready && idx_reg != 4'd0) begin
      idx_reg <= idx_reg - 4'd1;
    end
  end

  // Round-key storage; contents are only ever read after a full expansion,
  // so it carries no reset.
  always_ff @(posedge clk) begin
    if (load_en) begin
      rk_mem[0] <= key_in[255:128];
      rk_mem[1] <= key_in[127:0];
    end else if (step_en) begin
      rk_mem[rk_addr_even] <= w_step[255:128];
      if (iter_reg < 3'd6) rk_mem[rk_addr_even + 4'd1] <= w_step[127:0];
    end
  end

  assign rk_out = rk_valid ? rk_mem[idx_reg] : 128'h0;
  assign rk_idx = rk_valid ? idx_reg : 4'h0;

endmodule

// File: tb/tb_aes256_inv_key_sched.sv
// Self-checking bench for aes256_inv_key_sched. Expected round keys come from
// a word-by-word FIPS-197 key expansion whose S-box is derived from GF(2^8)
// inversion plus the affine map.
module tb_aes256_inv_key_sched;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [255:0] key_in;
  logic         key_valid;
  logic         key_ready;
  logic [127:0] rk_out;
  logic [3:0]   rk_idx;
  logic         rk_valid;
  logic         rk_ready;
  logic         busy;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [7:0]   sbox_m [256];
  logic [127:0] exp_rk [15];

  localparam logic [255:0] KEY_A3 =
    256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  always #5 clk = ~clk;

  aes256_inv_key_sched dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_in    (key_in),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .rk_out    (rk_out),
    .rk_idx    (rk_idx),
    .rk_valid  (rk_valid),
    .rk_ready  (rk_ready),
    .busy      (busy)
  );

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [15:0] d;
    d = {v, v} << n;
    return d[15:8];
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      if (x != 0)
        for (int y = 1; y < 256; y++)
          if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] sub_word_m(input logic [31:0] v);
    return {sbox_m[v[31:24]], sbox_m[v[23:16]], sbox_m[v[15:8]], sbox_m[v[7:0]]};
  endfunction

  task automatic compute_model(input logic [255:0] key);
    logic [31:0] w [60];
    logic [31:0] temp;
    logic [7:0]  rcon;
    rcon = 8'h01;
    for (int i = 0; i < 8; i++) w[i] = key[255 - 32*i -: 32];
    for (int i = 8; i < 60; i++) begin
      temp = w[i-1];
      if (i % 8 == 0) begin
        temp = sub_word_m({temp[23:0], temp[31:24]}) ^ {rcon, 24'h0};
        rcon = gmul(rcon, 8'h02);
      end else if (i % 8 == 4) begin
        temp = sub_word_m(temp);
      end
      w[i] = w[i-8] ^ temp;
    end
    for (int k = 0; k < 15; k++) exp_rk[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
  endtask

  function automatic logic [255:0] rand256();
    return {$urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Present a key for one cycle, optionally pulse an all-ones key during
  // EXPAND, and count rising edges from acceptance until rk_valid (99 = never).
  task automatic load_key(input logic [255:0] key, input int inject_at, output int lat);
    @(negedge clk);
    key_in = key; key_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    key_valid = 1'b0; key_in = rand256();
    lat = 0;
    while (!rk_valid && lat < 20) begin
      if (lat == inject_at) begin key_valid = 1'b1; key_in = '1; end
      else key_valid = 1'b0;
      @(posedge clk); lat++; @(negedge clk);
    end
    key_valid = 1'b0;
    if (!rk_valid) lat = 99;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      key_in = rand256(); key_valid = 1'($urandom()); rk_ready = 1'($urandom());
      @(negedge clk);
    end
    tests_run++; if (key_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_key_ready: got %b expected 1", key_ready); end
    tests_run++; if (rk_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_rk_valid: got %b expected 0", rk_valid); end
    tests_run++; if (rk_out !== 128'h0) begin tests_failed++; $display("FAIL reset_rk_out: got %h expected 0", rk_out); end
    tests_run++; if (rk_idx !== 4'h0) begin tests_failed++; $display("FAIL reset_rk_idx: got %h expected 0", rk_idx); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", busy); end
    key_valid = 1'b0; rk_ready = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    $display("[TB] reset checked");
  endtask

  task automatic test_first_rk();
    int lat;
    compute_model(KEY_A3);
    load_key(KEY_A3, -1, lat);
    tests_run++; if (lat != 7) begin tests_failed++; $display("FAIL first_latency: got %0d expected 7", lat); end
    tests_run++; if (rk_idx !== 4'd14) begin tests_failed++; $display("FAIL first_idx: got %0d expected 14", rk_idx); end
    tests_run++; if (rk_out !== 128'hfe4890d1e6188d0b046df344706c631e) begin tests_failed++; $display("FAIL first_rk_const: got %h expected fe4890d1e6188d0b046df344706c631e", rk_out); end
    tests_run++; if (rk_out !== exp_rk[14]) begin tests_failed++; $display("FAIL first_rk_model: got %h expected %h", rk_out, exp_rk[14]); end
    tests_run++; if (busy !== 1'b1 || key_ready !== 1'b0) begin tests_failed++; $display("FAIL first_busy: got busy=%b key_ready=%b expected 1/0", busy, key_ready); end
    $display("[TB] first round key idx %0d = %h", rk_idx, rk_out);
    rk_ready = 1'b1;
    repeat (15) @(negedge clk);
    rk_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int lat;
    compute_model(KEY_A3);
    load_key(KEY_A3, -1, lat);
    tests_run++; if (lat != 7) begin tests_failed++; $display("FAIL bp_latency: got %0d expected 7", lat); end
    rk_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tests_run++;
      if (rk_valid !== 1'b1 || rk_idx !== 4'd14 || rk_out !== exp_rk[14]) begin
        tests_failed++;
        $display("FAIL bp_stall_hold: got v=%b idx=%0d rk=%h expected v=1 idx=14 rk=%h", rk_valid, rk_idx, rk_out, exp_rk[14]);
      end
    end
    rk_ready = 1'b1;
    for (int k = 14; k >= 0; k--) begin
      tests_run++;
      if (rk_valid !== 1'b1 || rk_idx !== 4'(k) || rk_out !== exp_rk[k]) begin
        tests_failed++;
        $display("FAIL bp_drain: got v=%b idx=%0d rk=%h expected v=1 idx=%0d rk=%h", rk_valid, rk_idx, rk_out, k, exp_rk[k]);
      end
      if (k == 2) begin tests_run++; if (rk_out !== 128'h9ba354118e6925afa51a8b5f2067fcde) begin tests_failed++; $display("FAIL bp_idx2_const: got %h expected 9ba354118e6925afa51a8b5f2067fcde", rk_out); end end
      if (k == 1) begin tests_run++; if (rk_out !== 128'h1f352c073b6108d72d9810a30914dff4) begin tests_failed++; $display("FAIL bp_idx1_const: got %h expected 1f352c073b6108d72d9810a30914dff4", rk_out); end end
      if (k == 0) begin tests_run++; if (rk_out !== 128'h603deb1015ca71be2b73aef0857d7781) begin tests_failed++; $display("FAIL bp_idx0_const: got %h expected 603deb1015ca71be2b73aef0857d7781", rk_out); end end
      @(negedge clk);
    end
    tests_run++;
    if (key_ready !== 1'b1 || rk_valid !== 1'b0 || rk_out !== 128'h0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_return_idle: got key_ready=%b v=%b rk=%h busy=%b expected 1/0/0/0", key_ready, rk_valid, rk_out, busy);
    end
    rk_ready = 1'b0;
    $display("[TB] backpressure sequence done");
  endtask

  task automatic test_ignored_key();
    int lat;
    compute_model(KEY_A3);
    load_key(KEY_A3, 2, lat);
    tests_run++; if (lat != 7) begin tests_failed++; $display("FAIL ign_latency: got %0d expected 7", lat); end
    rk_ready = 1'b1;
    for (int k = 14; k >= 0; k--) begin
      tests_run++;
      if (rk_valid !== 1'b1 || rk_idx !== 4'(k) || rk_out !== exp_rk[k]) begin
        tests_failed++;
        $display("FAIL ign_drain: got v=%b idx=%0d rk=%h expected v=1 idx=%0d rk=%h", rk_valid, rk_idx, rk_out, k, exp_rk[k]);
      end
      @(negedge clk);
    end
    tests_run++; if (key_ready !== 1'b1) begin tests_failed++; $display("FAIL ign_key_ready: got %b expected 1", key_ready); end
    rk_ready = 1'b0;
    $display("[TB] ignored key pulse done");
  endtask

  task automatic test_reset_mid_serve();
    int lat;
    int n;
    compute_model(KEY_A3);
    load_key(KEY_A3, -1, lat);
    rk_ready = 1'b1;
    n = 0;
    while (rk_idx !== 4'd9 && n < 20) begin @(negedge clk); n++; end
    tests_run++; if (rk_idx !== 4'd9) begin tests_failed++; $display("FAIL rst_reach_idx9: got %0d expected 9", rk_idx); end
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if (rk_valid !== 1'b0 || rk_out !== 128'h0 || rk_idx !== 4'h0 || busy !== 1'b0 || key_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL rst_async: got v=%b rk=%h idx=%0d busy=%b key_ready=%b expected 0/0/0/0/1", rk_valid, rk_out, rk_idx, busy, key_ready);
    end
    rk_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    load_key(KEY_A3, -1, lat);
    tests_run++; if (lat != 7) begin tests_failed++; $display("FAIL rst_reload_latency: got %0d expected 7", lat); end
    tests_run++;
    if (rk_idx !== 4'd14 || rk_out !== exp_rk[14]) begin
      tests_failed++;
      $display("FAIL rst_reload_rk: got idx=%0d rk=%h expected idx=14 rk=%h", rk_idx, rk_out, exp_rk[14]);
    end
    rk_ready = 1'b1;
    repeat (15) @(negedge clk);
    rk_ready = 1'b0;
    $display("[TB] reset mid-serve done");
  endtask

  task automatic test_stream();
    int lat;
    logic [255:0] key;
    for (int t = 0; t < 3; t++) begin
      key = rand256();
      compute_model(key);
      rk_ready = 1'b1;
      load_key(key, -1, lat);
      tests_run++; if (lat != 7) begin tests_failed++; $display("FAIL stream_latency: got %0d expected 7", lat); end
      for (int k = 14; k >= 0; k--) begin
        tests_run++;
        if (rk_valid !== 1'b1 || rk_idx !== 4'(k) || rk_out !== exp_rk[k]) begin
          tests_failed++;
          $display("FAIL stream_rk: got v=%b idx=%0d rk=%h expected v=1 idx=%0d rk=%h", rk_valid, rk_idx, rk_out, k, exp_rk[k]);
        end
        @(negedge clk);
      end
      tests_run++; if (key_ready !== 1'b1) begin tests_failed++; $display("FAIL stream_key_ready: got %b expected 1", key_ready); end
      $display("[TB] stream key %h delivered", key);
    end
    rk_ready = 1'b0;
  endtask

  task automatic test_random_backpressure();
    int lat;
    int k;
    int guard;
    logic r;
    logic [255:0] key;
    for (int t = 0; t < 3; t++) begin
      key = rand256();
      compute_model(key);
      load_key(key, -1, lat);
      tests_run++; if (lat != 7) begin tests_failed++; $display("FAIL rbp_latency: got %0d expected 7", lat); end
      k = 14; guard = 0;
      while (k >= 0 && guard < 200) begin
        tests_run++;
        if (rk_valid !== 1'b1 || rk_idx !== 4'(k) || rk_out !== exp_rk[k]) begin
          tests_failed++;
          $display("FAIL rbp_rk: got v=%b idx=%0d rk=%h expected v=1 idx=%0d rk=%h", rk_valid, rk_idx, rk_out, k, exp_rk[k]);
        end
        r = 1'($urandom());
        rk_ready = r;
        @(posedge clk);
        if (r) k--;
        guard++;
        @(negedge clk);
      end
      rk_ready = 1'b0;
      tests_run++;
      if (k >= 0 || key_ready !== 1'b1) begin
        tests_failed++;
        $display("FAIL rbp_complete: got remaining=%0d key_ready=%b expected -1/1", k, key_ready);
      end
      $display("[TB] random backpressure key %h delivered", key);
    end
  endtask

  initial begin
    rst_n = 1'b0; key_in = '0; key_valid = 1'b0; rk_ready = 1'b0;
    build_sbox();
    test_reset();
    test_first_rk();
    test_backpressure();
    test_ignored_key();
    test_reset_mid_serve();
    test_stream();
    test_random_backpressure();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
